// File: rtl/icache_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch_arbiter
// Purpose  : Shares one I-Cache fetch port between the way0 and way1
//            instruction fetch units. Arbitrates round-robin and holds the
//            granted request and address stable until the cache answers.
//            Routes the returned instruction to the owning way. A redirect
//            (jumpFlag_i) squashes the in-flight fetch, and the late
//            response is drained and discarded.
// Ports    :
//   clk, reset_n            core clock, asynchronous active-low reset
//   jumpFlag_i              redirect: squash in-flight and new fetches
//   way0_* / way1_*         per-way request, address, response valid, data
//   request_o               fetch request to the I-Cache
//   instAddr_fetch_o        registered fetch address to the I-Cache
//   dataOk_i, inst_fetch_i  response valid and instruction from the I-Cache
//   grant_o                 one-hot owner {way1,way0}; 0 when idle/draining
//   timeout_o               sticky flag: cache did not answer in time
// Revision : 1.0 - initial release
// ============================================================================
module icache_fetch_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  jumpFlag_i,
  // way0 fetch unit
  input  logic                  way0_request_i,
  input  logic [ADDR_WIDTH-1:0] way0_instAddr_fetch_i,
  output logic                  way0_dataOk_o,
  output logic [INST_WIDTH-1:0] way0_inst_fetch_o,
  // way1 fetch unit
  input  logic                  way1_request_i,
  input  logic [ADDR_WIDTH-1:0] way1_instAddr_fetch_i,
  output logic                  way1_dataOk_o,
  output logic [INST_WIDTH-1:0] way1_inst_fetch_o,
  // I-Cache side
  output logic                  request_o,
  output logic [ADDR_WIDTH-1:0] instAddr_fetch_o,
  input  logic                  dataOk_i,
  input  logic [INST_WIDTH-1:0] inst_fetch_i,
  // status
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY0 = 2'd1,
    S_BUSY1 = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_request;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_grant;
  logic                  r_timeout;
  logic                  r_last_grant;   // 0 = way0 served last, 1 = way1
  logic [c_cnt_w-1:0]    r_wait_cnt;

  logic                  w_busy0;
  logic                  w_busy1;
  logic                  w_served;
  logic                  w_eff_last;
  logic                  w_any_req;
  logic                  w_pick1;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [c_cnt_w-1:0]    w_cnt_next;
  logic                  w_ok0;
  logic                  w_ok1;

  assign w_busy0   = (r_state == S_BUSY0);
  assign w_busy1   = (r_state == S_BUSY1);
  assign w_served  = (w_busy0 | w_busy1) & dataOk_i;
  assign w_any_req = way0_request_i | way1_request_i;

  // When a way is being served this cycle it becomes the last grant
  // immediately, so the other way wins a tie in the back-to-back re-issue.
  assign w_eff_last = w_served ? w_busy1 : r_last_grant;

  // way1 wins if it is the only requester, or on a tie when way0 was last.
  assign w_pick1    = way1_request_i & (~way0_request_i | ~w_eff_last);
  assign w_win_addr = w_pick1 ? way1_instAddr_fetch_i : way0_instAddr_fetch_i;

  // A new fetch starts from IDLE, or back-to-back on a normal completion.
  // A redirect blocks both.
  assign w_issue = ~jumpFlag_i & w_any_req &
                   ((r_state == S_IDLE) | w_served);

  // Saturating wait counter step.
  assign w_cnt_next = (r_wait_cnt == c_cnt_max) ? c_cnt_max : r_wait_cnt + 1'b1;

  // Responses are forwarded combinationally in the cycle the cache answers.
  assign w_ok0 = w_busy0 & dataOk_i & ~jumpFlag_i;
  assign w_ok1 = w_busy1 & dataOk_i & ~jumpFlag_i;

  assign way0_dataOk_o     = w_ok0;
  assign way1_dataOk_o     = w_ok1;
  assign way0_inst_fetch_o = w_ok0 ? inst_fetch_i : '0;
  assign way1_inst_fetch_o = w_ok1 ? inst_fetch_i : '0;

  assign request_o        = r_request;
  assign instAddr_fetch_o = r_addr;
  assign grant_o          = r_grant;
  assign timeout_o        = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_request    <= 1'b0;
      r_addr       <= '0;
      r_grant      <= 2'b00;
      r_timeout    <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
    end else if (w_issue) begin
      r_state    <= w_pick1 ? S_BUSY1 : S_BUSY0;
      r_request  <= 1'b1;
      r_addr     <= w_win_addr;
      r_grant    <= w_pick1 ? 2'b10 : 2'b01;
      r_wait_cnt <= '0;
      if (w_served) begin
        r_last_grant <= w_busy1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // Nothing pending or redirect active: stay idle.
          r_request <= 1'b0;
          r_grant   <= 2'b00;
        end

        S_BUSY0, S_BUSY1: begin
          if (dataOk_i) begin
            // Completion with no follow-on fetch; a squashed completion
            // leaves the round-robin pointer untouched.
            if (!jumpFlag_i) begin
              r_last_grant <= w_busy1;
            end
            r_state   <= S_IDLE;
            r_request <= 1'b0;
            r_grant   <= 2'b00;
          end else if (jumpFlag_i) begin
            // Keep the address and request up so the cache can finish
            // the outstanding access; its data is thrown away.
            r_state    <= S_DRAIN;
            r_grant    <= 2'b00;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_cnt_next;
            if (w_cnt_next == c_cnt_max) begin
              r_timeout <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (dataOk_i) begin
            r_state   <= S_IDLE;
            r_request <= 1'b0;
            r_grant   <= 2'b00;
          end else begin
            r_wait_cnt <= w_cnt_next;
            if (w_cnt_next == c_cnt_max) begin
              r_timeout <= 1'b1;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_request <= 1'b0;
          r_grant   <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fetch_arbiter
// Purpose  : Self-checking bench for icache_fetch_arbiter. Directed stimulus
//            pushes expected way responses and expected cache-side addresses
//            into queues; a negedge monitor pops and compares them whenever
//            the DUT presents a way response or a cache handshake completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_fetch_arbiter;

  localparam int AW = 32;
  localparam int IW = 32;

  typedef struct {
    logic          way;
    logic [IW-1:0] inst;
  } resp_t;

  logic          clk;
  logic          reset_n;
  logic          jumpFlag_i;
  logic          way0_request_i;
  logic [AW-1:0] way0_instAddr_fetch_i;
  logic          way0_dataOk_o;
  logic [IW-1:0] way0_inst_fetch_o;
  logic          way1_request_i;
  logic [AW-1:0] way1_instAddr_fetch_i;
  logic          way1_dataOk_o;
  logic [IW-1:0] way1_inst_fetch_o;
  logic          request_o;
  logic [AW-1:0] instAddr_fetch_o;
  logic          dataOk_i;
  logic [IW-1:0] inst_fetch_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  resp_t         exp_resp[$];
  logic [AW-1:0] exp_addr[$];
  resp_t         mon_r;
  logic [AW-1:0] mon_a;
  int            n_cmp = 0;
  int            n_err = 0;

  icache_fetch_arbiter #(
    .ADDR_WIDTH     (AW),
    .INST_WIDTH     (IW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .jumpFlag_i            (jumpFlag_i),
    .way0_request_i        (way0_request_i),
    .way0_instAddr_fetch_i (way0_instAddr_fetch_i),
    .way0_dataOk_o         (way0_dataOk_o),
    .way0_inst_fetch_o     (way0_inst_fetch_o),
    .way1_request_i        (way1_request_i),
    .way1_instAddr_fetch_i (way1_instAddr_fetch_i),
    .way1_dataOk_o         (way1_dataOk_o),
    .way1_inst_fetch_o     (way1_inst_fetch_o),
    .request_o             (request_o),
    .instAddr_fetch_o      (instAddr_fetch_o),
    .dataOk_i              (dataOk_i),
    .inst_fetch_i          (inst_fetch_i),
    .grant_o               (grant_o),
    .timeout_o             (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_resp(input logic way, input logic [IW-1:0] inst);
    resp_t r;
    r.way  = way;
    r.inst = inst;
    exp_resp.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    jumpFlag_i            = 1'b0;
    way0_request_i        = 1'b0;
    way0_instAddr_fetch_i = '0;
    way1_request_i        = 1'b0;
    way1_instAddr_fetch_i = '0;
    dataOk_i              = 1'b0;
    inst_fetch_i          = '0;
    reset_n               = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Monitor: way responses and cache handshakes against the queues.
  always @(negedge clk) begin
    if (way0_dataOk_o || way1_dataOk_o) begin
      if (exp_resp.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: got way0=%0b way1=%0b expected no response",
                 way0_dataOk_o, way1_dataOk_o);
      end else begin
        mon_r = exp_resp.pop_front();
        check("resp_way", {31'd0, way1_dataOk_o}, {31'd0, mon_r.way});
        check("resp_inst", way1_dataOk_o ? way1_inst_fetch_o : way0_inst_fetch_o, mon_r.inst);
      end
    end
    if (request_o && dataOk_i) begin
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL hs_unexpected: got handshake addr 0x%0h expected none", instAddr_fetch_o);
      end else begin
        mon_a = exp_addr.pop_front();
        check("hs_addr", instAddr_fetch_o, mon_a);
      end
    end
    check("both_ok", {31'd0, way0_dataOk_o & way1_dataOk_o}, 32'd0);
    if (!way0_dataOk_o) check("way0_inst_zero", way0_inst_fetch_o, 32'd0);
    if (!way1_dataOk_o) check("way1_inst_zero", way1_inst_fetch_o, 32'd0);
  end

  initial begin
    jumpFlag_i            = 1'b0;
    way0_request_i        = 1'b0;
    way0_instAddr_fetch_i = '0;
    way1_request_i        = 1'b0;
    way1_instAddr_fetch_i = '0;
    dataOk_i              = 1'b0;
    inst_fetch_i          = '0;
    reset_n               = 1'b1;
    #2 reset_n = 1'b0;

    // Reset state
    step();
    neg();
    check("rst_request", {31'd0, request_o}, 32'd0);
    check("rst_addr", instAddr_fetch_o, 32'd0);
    check("rst_grant", {30'd0, grant_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    step();
    reset_n = 1'b1;

    // 1: single way0 fetch, address held while requester changes it
    do_reset();
    way0_request_i = 1'b1; way0_instAddr_fetch_i = 32'h8000_0000;
    neg();
    check("t1_req_latency", {31'd0, request_o}, 32'd0);
    step();
    neg();
    check("t1_request", {31'd0, request_o}, 32'd1);
    check("t1_grant", {30'd0, grant_o}, 32'd1);
    check("t1_addr", instAddr_fetch_o, 32'h8000_0000);
    step();
    way0_instAddr_fetch_i = 32'h0000_1234;
    neg();
    check("t1_addr_hold", instAddr_fetch_o, 32'h8000_0000);
    step();
    exp_addr.push_back(32'h8000_0000);
    push_resp(1'b0, 32'h0000_0013);
    dataOk_i = 1'b1; inst_fetch_i = 32'h0000_0013; way0_request_i = 1'b0;
    neg();
    check("t1_way0_ok", {31'd0, way0_dataOk_o}, 32'd1);
    check("t1_request_c4", {31'd0, request_o}, 32'd1);
    step();
    dataOk_i = 1'b0; inst_fetch_i = '0;
    neg();
    check("t1_idle_request", {31'd0, request_o}, 32'd0);
    check("t1_idle_grant", {30'd0, grant_o}, 32'd0);

    // 2: both requesting, round-robin alternation
    do_reset();
    way0_request_i = 1'b1; way0_instAddr_fetch_i = 32'h100;
    way1_request_i = 1'b1; way1_instAddr_fetch_i = 32'h200;
    step();
    neg();
    check("t2_first_grant", {30'd0, grant_o}, 32'd1);
    exp_addr.push_back(32'h100);
    push_resp(1'b0, 32'hA0);
    dataOk_i = 1'b1; inst_fetch_i = 32'hA0;
    step();
    way0_instAddr_fetch_i = 32'h104; way1_instAddr_fetch_i = 32'h204;
    exp_addr.push_back(32'h200);
    push_resp(1'b1, 32'hB1);
    inst_fetch_i = 32'hB1;
    neg();
    check("t2_second_grant", {30'd0, grant_o}, 32'd2);
    step();
    exp_addr.push_back(32'h104);
    push_resp(1'b0, 32'hC0);
    inst_fetch_i = 32'hC0; way0_request_i = 1'b0;
    neg();
    check("t2_third_grant", {30'd0, grant_o}, 32'd1);
    step();
    exp_addr.push_back(32'h204);
    push_resp(1'b1, 32'hD1);
    inst_fetch_i = 32'hD1; way1_request_i = 1'b0;
    neg();
    check("t2_fourth_grant", {30'd0, grant_o}, 32'd2);
    step();
    dataOk_i = 1'b0; inst_fetch_i = '0;
    neg();
    check("t2_idle_request", {31'd0, request_o}, 32'd0);

    // 3: redirect in BUSY1, response drained three cycles later
    do_reset();
    way1_request_i = 1'b1; way1_instAddr_fetch_i = 32'h300;
    step();
    neg();
    check("t3_grant_way1", {30'd0, grant_o}, 32'd2);
    jumpFlag_i = 1'b1; way1_request_i = 1'b0;
    step();
    jumpFlag_i = 1'b0;
    neg();
    check("t3_drain_grant", {30'd0, grant_o}, 32'd0);
    check("t3_drain_request", {31'd0, request_o}, 32'd1);
    check("t3_drain_addr", instAddr_fetch_o, 32'h300);
    step();
    step();
    exp_addr.push_back(32'h300);
    dataOk_i = 1'b1; inst_fetch_i = 32'hDEAD;
    neg();
    check("t3_no_way1_ok", {31'd0, way1_dataOk_o}, 32'd0);
    step();
    // dataOk while idle is ignored; redirect in idle blocks the grant
    inst_fetch_i = 32'h55; jumpFlag_i = 1'b1;
    way0_request_i = 1'b1; way0_instAddr_fetch_i = 32'h400;
    neg();
    check("t3_idle_request", {31'd0, request_o}, 32'd0);
    check("t3_idle_no_ok", {31'd0, way0_dataOk_o}, 32'd0);
    step();
    dataOk_i = 1'b0; inst_fetch_i = '0; jumpFlag_i = 1'b0;
    neg();
    check("t3_jump_idle_no_grant", {31'd0, request_o}, 32'd0);
    step();
    neg();
    check("t4_grant_way0", {30'd0, grant_o}, 32'd1);

    // 4: redirect coincident with dataOk in BUSY0, way0 still requesting
    step();
    exp_addr.push_back(32'h400);
    dataOk_i = 1'b1; jumpFlag_i = 1'b1; inst_fetch_i = 32'hBEEF;
    neg();
    check("t4_no_way0_ok", {31'd0, way0_dataOk_o}, 32'd0);
    step();
    dataOk_i = 1'b0; jumpFlag_i = 1'b0; inst_fetch_i = '0; way0_request_i = 1'b0;
    neg();
    check("t4_idle_request", {31'd0, request_o}, 32'd0);
    check("t4_idle_grant", {30'd0, grant_o}, 32'd0);
    check("t4_no_timeout", {31'd0, timeout_o}, 32'd0);

    // 5: cache never answers
    do_reset();
    way0_request_i = 1'b1; way0_instAddr_fetch_i = 32'h500;
    step();
    step();
    step();
    step();
    neg();
    check("t5_timeout_before", {31'd0, timeout_o}, 32'd0);
    step();
    neg();
    check("t5_timeout_set", {31'd0, timeout_o}, 32'd1);
    step();
    step();
    step();
    neg();
    check("t5_timeout_sticky", {31'd0, timeout_o}, 32'd1);
    check("t5_request_held", {31'd0, request_o}, 32'd1);
    check("t5_grant_held", {30'd0, grant_o}, 32'd1);

    // 6: asynchronous reset mid-fetch, later stray dataOk ignored
    step();
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_request", {31'd0, request_o}, 32'd0);
    check("t6_async_grant", {30'd0, grant_o}, 32'd0);
    check("t6_async_timeout", {31'd0, timeout_o}, 32'd0);
    way0_request_i = 1'b0;
    step();
    reset_n = 1'b1;
    dataOk_i = 1'b1; inst_fetch_i = 32'h77;
    neg();
    check("t6_stray_no_ok", {31'd0, way0_dataOk_o}, 32'd0);
    step();
    dataOk_i = 1'b0; inst_fetch_i = '0;
    neg();
    check("t6_stray_request", {31'd0, request_o}, 32'd0);

    step();
    check("resp_queue_empty", exp_resp.size(), 32'd0);
    check("addr_queue_empty", exp_addr.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
